conv_stream_master: RTL and testbench
=====================================

// Module: conv_stream_master
// PURPOSE
//   Transmitter/receiver counterpart of the 128x32 convolution engine: streams a stored
//   x vector and filter f into the engine's s_*_x / s_*_f ports and collects CONV_N
//   results from its m_*_y port into a result RAM. Host loads x/f RAMs, pulses start,
//   waits for done, then reads results. Used as on-chip test driver and system front-end.
// PARAMETERS
//   DATA_N    128  x samples per job
//   FILTER_N  32   filter taps per job
//   Y_W       21   result width (signed)
//   local: CONV_N = DATA_N-FILTER_N+1 (97); LG_DATA_N/LG_FILTER_N/LG_CONV_N = $clog2 of each
// PORTS
//   clk        in   1          rising-edge clock
//   reset_n    in   1          asynchronous, active-low reset
//   h_wr_en    in   1          host write strobe
//   h_wr_sel   in   1          0 = x RAM, 1 = f RAM
//   h_wr_addr  in   LG_DATA_N  write address (f uses low LG_FILTER_N bits)
//   h_wr_data  in   8 signed   write data
//   start      in   1          begin one job (sampled only in IDLE)
//   busy       out  1          high from start accept until done
//   done       out  1          one-cycle pulse at job completion
//   h_rd_addr  in   LG_CONV_N  result read address
//   h_rd_data  out  Y_W signed result read data, 1-cycle latency
//   m_valid_x  out  1 / m_ready_x in 1 / m_data_x out 8 signed   x stream
//   m_valid_f  out  1 / m_ready_f in 1 / m_data_f out 8 signed   f stream
//   s_valid_y  in   1 / s_ready_y out 1 / s_data_y in Y_W signed y stream
// BEHAVIOUR
//   Reset: busy=0, done=0, m_valid_x=m_valid_f=0, s_ready_y=0, h_rd_data=0, FSM=IDLE,
//     counters x_cnt/f_cnt/y_cnt=0. RAM contents not reset.
//   Handshake: beat transfers on valid&ready at posedge. valid never depends on ready;
//     once asserted, valid and data hold until the beat transfers.
//   FSM IDLE -> RUN on start (busy=1 next cycle). start in RUN/DONE ignored.
//   RUN: x and f channels independent. m_valid_x=(x_cnt<DATA_N), m_data_x=x_ram[x_cnt];
//     m_valid_f=(f_cnt<FILTER_N), m_data_f=f_ram[f_cnt]; each counter +1 per beat.
//     s_ready_y=(y_cnt<CONV_N); each y beat writes y_ram[y_cnt], y_cnt+1. y beats may
//     arrive while x/f still streaming; no ordering imposed.
//   RUN -> DONE when x_cnt==DATA_N & f_cnt==FILTER_N & y_cnt==CONV_N (incl. same cycle
//     as final y beat). DONE: done=1 for exactly one cycle, busy=0, clear counters -> IDLE.
//   Job latency from start: >= DATA_N cycles with always-ready engine; no bubbles inserted
//     by this block (back-to-back beats each cycle while ready held).
//   Host writes: accepted only in IDLE; writes while busy dropped. h_wr_sel=1 with
//     h_wr_addr>=FILTER_N aliases to low bits (no error).
//   Reads: h_rd_data <= y_ram[h_rd_addr] every cycle; addr>=CONV_N returns 0. Reads legal
//     while busy (return partially written data).
//   Extra y beats after CONV_N are not accepted (s_ready_y=0); engine stalls.
//   reset_n low mid-job: outputs/FSM return to reset values immediately; partial job
//     abandoned; next start restarts all counters from 0.
// TESTING
//   1 x[i]=i-64, f[j]=1, engine always ready, start -> 128 x + 32 f beats, done after 97th y,
//     h_rd_data(0)=sum(x[0..31]) = -1552 from model.
//   2 m_ready_x toggled 1,0,0,1 randomly -> m_data_x stable while stalled, no beat lost/dup.
//   3 s_valid_y fed 97 beats then a 98th -> s_ready_y low on 98th, y_ram[96] = 97th value.
//   4 start pulsed again at cycle 5 of RUN and h_wr_en during RUN -> both ignored, RAM intact.
//   5 reset_n low after 40 x beats -> valids low at once; restart streams x[0] first.
//   6 final x beat and final y beat in same cycle -> single done pulse next cycle, busy=0.

Source files
------------

// File: rtl/conv_stream_master_if.sv
// conv_stream_master_if
//   Stream bundle between the convolution test driver and the convolution engine.
//   x and f are outbound 8-bit signed streams; y is the inbound Y_W-bit signed
//   result stream. Each channel uses valid/ready; a beat moves when both are high
//   at a rising clock edge.
//   master modport : the driver side (drives x/f valid+data and y ready)
//   slave  modport : the engine side (drives x/f ready and y valid+data)
interface conv_stream_master_if #(
  parameter int Y_W = 21
);
  logic                  m_valid_x;
  logic                  m_ready_x;
  logic signed [7:0]     m_data_x;
  logic                  m_valid_f;
  logic                  m_ready_f;
  logic signed [7:0]     m_data_f;
  logic                  s_valid_y;
  logic                  s_ready_y;
  logic signed [Y_W-1:0] s_data_y;

  modport master (
    output m_valid_x, m_data_x, input m_ready_x,
    output m_valid_f, m_data_f, input m_ready_f,
    input  s_valid_y, s_data_y, output s_ready_y
  );

  modport slave (
    input  m_valid_x, m_data_x, output m_ready_x,
    input  m_valid_f, m_data_f, output m_ready_f,
    output s_valid_y, s_data_y, input s_ready_y
  );
endinterface

// File: rtl/conv_stream_master.sv
// conv_stream_master
//   Front-end / test driver for the convolution engine. The host fills the x and f
//   RAMs while idle, pulses start, and the block streams DATA_N x samples and
//   FILTER_N taps out while collecting CONV_N results into the y RAM. done pulses
//   for one cycle once every stream has completed; results are then read back.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   h_wr_en/sel/addr/data host write into x RAM (sel=0) or f RAM (sel=1), idle only
//   start                 begin a job (honoured only in IDLE)
//   busy, done            job in progress / one-cycle completion pulse
//   h_rd_addr, h_rd_data  result read port, one cycle latency, 0 beyond CONV_N-1
//   strm                  x/f outbound and y inbound valid/ready streams
module conv_stream_master #(
  parameter int DATA_N   = 128,
  parameter int FILTER_N = 32,
  parameter int Y_W      = 21,
  localparam int CONV_N      = DATA_N - FILTER_N + 1,
  localparam int LG_DATA_N   = $clog2(DATA_N),
  localparam int LG_FILTER_N = $clog2(FILTER_N),
  localparam int LG_CONV_N   = $clog2(CONV_N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  h_wr_en,
  input  logic                  h_wr_sel,
  input  logic [LG_DATA_N-1:0]  h_wr_addr,
  input  logic signed [7:0]     h_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [LG_CONV_N-1:0]  h_rd_addr,
  output logic signed [Y_W-1:0] h_rd_data,
  conv_stream_master_if.master  strm
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Counters carry one extra bit so they can sit at the "all sent" value.
  localparam logic [LG_DATA_N:0]   X_END = (LG_DATA_N+1)'(DATA_N);
  localparam logic [LG_FILTER_N:0] F_END = (LG_FILTER_N+1)'(FILTER_N);
  localparam logic [LG_CONV_N:0]   Y_END = (LG_CONV_N+1)'(CONV_N);

  state_e                 state_q, state_d;
  logic [LG_DATA_N:0]     x_cnt_q, x_cnt_d;
  logic [LG_FILTER_N:0]   f_cnt_q, f_cnt_d;
  logic [LG_CONV_N:0]     y_cnt_q, y_cnt_d;
  logic signed [Y_W-1:0]  rd_data_q;

  logic signed [7:0]      x_ram [DATA_N];
  logic signed [7:0]      f_ram [FILTER_N];
  logic signed [Y_W-1:0]  y_ram [CONV_N];

  logic valid_x, valid_f, ready_y;
  logic x_fire, f_fire, y_fire;

  // Valids/ready come only from state and counters, never from the far side's
  // handshake, so a presented beat stays put until it is taken.
  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    y_cnt_d = y_cnt_q;
    valid_x = 1'b0;
    valid_f = 1'b0;
    ready_y = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        valid_x = (x_cnt_q < X_END);
        valid_f = (f_cnt_q < F_END);
        ready_y = (y_cnt_q < Y_END);
        if (valid_x && strm.m_ready_x) x_cnt_d = x_cnt_q + (LG_DATA_N+1)'(1);
        if (valid_f && strm.m_ready_f) f_cnt_d = f_cnt_q + (LG_FILTER_N+1)'(1);
        if (ready_y && strm.s_valid_y) y_cnt_d = y_cnt_q + (LG_CONV_N+1)'(1);
        // Looking at next-state counts lets the job finish on the same edge
        // as its last beat, with done following one cycle later.
        if (x_cnt_d == X_END && f_cnt_d == F_END && y_cnt_d == Y_END) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        x_cnt_d = '0;
        f_cnt_d = '0;
        y_cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign x_fire = valid_x && strm.m_ready_x;
  assign f_fire = valid_f && strm.m_ready_f;
  assign y_fire = ready_y && strm.s_valid_y;

  assign strm.m_valid_x = valid_x;
  assign strm.m_valid_f = valid_f;
  assign strm.s_ready_y = ready_y;
  // The low counter bits index the RAM; the unused wrap value is masked by valid.
  assign strm.m_data_x  = x_ram[x_cnt_q[LG_DATA_N-1:0]];
  assign strm.m_data_f  = f_ram[f_cnt_q[LG_FILTER_N-1:0]];
  assign h_rd_data      = rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_cnt_q   <= '0;
      f_cnt_q   <= '0;
      y_cnt_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      y_cnt_q   <= y_cnt_d;
      rd_data_q <= ({1'b0, h_rd_addr} < Y_END) ? y_ram[h_rd_addr] : '0;
    end
  end

  // Host writes land only while idle; f addresses alias onto the low bits.
  always_ff @(posedge clk) begin
    if (h_wr_en && state_q == IDLE) begin
      if (h_wr_sel) f_ram[h_wr_addr[LG_FILTER_N-1:0]] <= h_wr_data;
      else          x_ram[h_wr_addr]                  <= h_wr_data;
    end
    if (y_fire) y_ram[y_cnt_q[LG_CONV_N-1:0]] <= strm.s_data_y;
  end

  // x_fire/f_fire are kept for readability of the handshake; fold them into a
  // no-op so they count as used.
  logic unused_fire;
  assign unused_fire = x_fire ^ f_fire;

endmodule

// File: tb/tb_conv_stream_master.sv
module tb_conv_stream_master;
  localparam int DATA_N = 128, FILTER_N = 32, Y_W = 21;
  localparam int CONV_N = DATA_N - FILTER_N + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic h_wr_en = 0, h_wr_sel = 0, start = 0;
  logic [6:0] h_wr_addr = '0, h_rd_addr = '0;
  logic signed [7:0] h_wr_data = '0;
  logic busy, done;
  logic signed [Y_W-1:0] h_rd_data;

  conv_stream_master_if #(.Y_W(Y_W)) sif();

  conv_stream_master #(.DATA_N(DATA_N), .FILTER_N(FILTER_N), .Y_W(Y_W)) dut (
    .clk(clk), .reset_n(reset_n), .h_wr_en(h_wr_en), .h_wr_sel(h_wr_sel),
    .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data), .start(start), .busy(busy),
    .done(done), .h_rd_addr(h_rd_addr), .h_rd_data(h_rd_data), .strm(sif)
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state
  logic signed [7:0]     x_m [DATA_N];
  logic signed [7:0]     f_m [FILTER_N];
  logic signed [Y_W-1:0] y_src [CONV_N+1];
  logic signed [Y_W-1:0] y_m [CONV_N];
  logic signed [7:0]     exp_x[$], exp_f[$];
  int                    rd_q[$];

  // Engine model controls
  int  x_mode = 0, f_mode = 0, y_mode = 0, y_limit = CONV_N;
  bit  x_hold = 0, y_hold = 0, y_en = 0;
  bit  rd_req = 0, rd_req_d = 0;
  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor bookkeeping
  int x_beats = 0, f_beats = 0, y_beats = 0, done_cnt = 0, done0 = 0;
  int first_x_cyc = -1, last_x_cyc = 0, last_y_cyc = 0, done_cyc = 0;
  bit x_stall = 0, f_stall = 0, done_prev = 0;
  logic signed [7:0] x_stall_d, f_stall_d;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int conv_ref(input int k);
    int s = 0;
    for (int j = 0; j < FILTER_N; j++) s += int'(x_m[k+j]) * int'(f_m[j]);
    return s;
  endfunction

  // Engine side drivers (drive #1 after the edge)
  always @(posedge clk) begin
    #1;
    case (x_mode)
      1:       sif.m_ready_x = 1'($urandom_range(0, 1));
      2:       sif.m_ready_x = !(x_hold && x_beats == DATA_N-1);
      default: sif.m_ready_x = 1'b1;
    endcase
    sif.m_ready_f = (f_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!y_en) begin
      sif.s_valid_y = 1'b0;
    end else if (!(sif.s_valid_y && !sif.s_ready_y)) begin
      sif.s_valid_y = (y_beats < y_limit) && !(y_hold && y_beats == CONV_N-1) &&
                      (y_mode == 0 || $urandom_range(0, 1) == 1);
    end
    sif.s_data_y = y_src[(y_beats <= CONV_N) ? y_beats : CONV_N];
  end

  // Monitor / scoreboard (sampled on the falling edge)
  always @(negedge clk) begin
    if (!reset_n) begin
      x_stall = 0; f_stall = 0; done_prev = 0;
    end else begin
      if (x_stall) begin
        chk("x_hold_valid", sif.m_valid_x, 1);
        chk("x_hold_data", sif.m_data_x, x_stall_d);
      end
      if (f_stall) begin
        chk("f_hold_valid", sif.m_valid_f, 1);
        chk("f_hold_data", sif.m_data_f, f_stall_d);
      end
      x_stall = sif.m_valid_x && !sif.m_ready_x; x_stall_d = sif.m_data_x;
      f_stall = sif.m_valid_f && !sif.m_ready_f; f_stall_d = sif.m_data_f;
      if (sif.m_valid_x && sif.m_ready_x) begin
        if (exp_x.size() == 0) begin
          checks++; errors++; $display("FAIL x_extra_beat actual=%0d required=none", sif.m_data_x);
        end else chk("x_data", sif.m_data_x, exp_x.pop_front());
        if (x_beats == 0) first_x_cyc = cyc;
        x_beats++; last_x_cyc = cyc;
      end
      if (sif.m_valid_f && sif.m_ready_f) begin
        if (exp_f.size() == 0) begin
          checks++; errors++; $display("FAIL f_extra_beat actual=%0d required=none", sif.m_data_f);
        end else chk("f_data", sif.m_data_f, exp_f.pop_front());
        f_beats++;
      end
      if (sif.s_valid_y && sif.s_ready_y) begin
        if (y_beats < CONV_N) y_m[y_beats] = sif.s_data_y;
        y_beats++; last_y_cyc = cyc;
      end
      if (rd_req_d) chk("rd_data", h_rd_data, rd_q.pop_front());
      if (done_prev) chk("done_width", done, 0);
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
      done_prev = done;
    end
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic host_write(input logic sel, input logic [6:0] a, input logic signed [7:0] d);
    h_wr_en = 1; h_wr_sel = sel; h_wr_addr = a; h_wr_data = d;
    tick;
    h_wr_en = 0;
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < DATA_N; i++) begin
      x_m[i] = (mode == 0) ? 8'(i - 64) : 8'($urandom);
      host_write(1'b0, 7'(i), x_m[i]);
    end
    for (int j = 0; j < FILTER_N; j++) begin
      f_m[j] = (mode == 0) ? 8'sd1 : 8'($urandom);
      // aliased f addresses must land on the low bits
      host_write(1'b1, 7'(j + ((mode == 0) ? 0 : 32 * $urandom_range(0, 3))), f_m[j]);
    end
  endtask

  task automatic start_job(input bit conv_y);
    exp_x.delete(); exp_f.delete();
    for (int i = 0; i < DATA_N; i++) exp_x.push_back(x_m[i]);
    for (int j = 0; j < FILTER_N; j++) exp_f.push_back(f_m[j]);
    for (int k = 0; k < CONV_N; k++) y_src[k] = conv_y ? Y_W'(conv_ref(k)) : Y_W'($urandom);
    y_src[CONV_N] = Y_W'($urandom);
    x_beats = 0; f_beats = 0; y_beats = 0; first_x_cyc = -1;
    done0 = done_cnt;
    y_en = 1; start = 1;
    tick;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == done0 && n < budget) begin tick; n++; end
    checks++;
    if (done_cnt == done0) begin
      errors++; $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic job_checks(input string name);
    chk({name, "_x_beats"}, x_beats, DATA_N);
    chk({name, "_f_beats"}, f_beats, FILTER_N);
    chk({name, "_y_beats"}, y_beats, CONV_N);
    chk({name, "_done_pulses"}, done_cnt - done0, 1);
    chk({name, "_x_left"}, exp_x.size(), 0);
    chk({name, "_f_left"}, exp_f.size(), 0);
    tick;
    chk({name, "_busy_after"}, busy, 0);
    y_en = 0;
    for (int a = 0; a < CONV_N + 3; a++) begin
      h_rd_addr = 7'(a); rd_req = 1;
      rd_q.push_back((a < CONV_N) ? int'(y_m[a]) : 0);
      tick;
    end
    rd_req = 0;
    tick; tick;
    chk({name, "_rd_left"}, rd_q.size(), 0);
    $display("job %s: x=%0d f=%0d y=%0d dones=%0d errors=%0d", name, x_beats, f_beats,
             y_beats, done_cnt - done0, errors);
  endtask

  initial begin
    int n;
    sif.m_ready_x = 0; sif.m_ready_f = 0; sif.s_valid_y = 0; sif.s_data_y = '0;
    #3 reset_n = 0;
    tick; tick;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_valid_x", sif.m_valid_x, 0); chk("rst_valid_f", sif.m_valid_f, 0);
    chk("rst_ready_y", sif.s_ready_y, 0); chk("rst_rd_data", h_rd_data, 0);
    reset_n = 1;
    tick;

    // 1: ramp x, unit filter, always-ready engine
    load(0);
    x_mode = 0; f_mode = 0; y_mode = 0; y_limit = CONV_N;
    start_job(1);
    chk("t1_busy", busy, 1);
    wait_done("t1", 400);
    chk("t1_x_back_to_back", last_x_cyc - first_x_cyc, DATA_N - 1);
    chk("t1_done_after_last_x", done_cyc - last_x_cyc, 1);
    job_checks("t1");
    h_rd_addr = 7'd0; rd_req = 1; rd_q.push_back(-1552); tick; rd_req = 0; tick; tick;

    // 2: random data, random stalls on every channel
    load(1);
    x_mode = 1; f_mode = 1; y_mode = 1;
    start_job(0);
    wait_done("t2", 2000);
    job_checks("t2");

    // 3: results arrive ahead of x, and a 98th result is offered
    x_mode = 1; f_mode = 0; y_mode = 0; y_limit = CONV_N + 1;
    start_job(0);
    n = 0;
    while (y_beats < CONV_N && n < 1000) begin tick; n++; end
    tick; tick;
    chk("t3_ready_98th", sif.s_ready_y, 0);
    chk("t3_still_busy", busy, 1);
    wait_done("t3", 2000);
    job_checks("t3");
    y_limit = CONV_N;

    // 4: start and host writes while running are ignored
    x_mode = 1; f_mode = 1; y_mode = 1;
    start_job(0);
    repeat (4) tick;
    start = 1; h_wr_en = 1; h_wr_sel = 0; h_wr_addr = 7'd100; h_wr_data = ~x_m[100];
    tick;
    start = 0; h_wr_sel = 1; h_wr_addr = 7'd31; h_wr_data = ~f_m[31];
    tick;
    h_wr_en = 0;
    wait_done("t4", 2000);
    job_checks("t4");
    repeat (3) tick;
    chk("t4_no_restart", busy, 0);

    // 5: reset after 40 x beats, then restart from scratch
    x_mode = 0; f_mode = 0; y_mode = 1;
    start_job(0);
    n = 0;
    while (x_beats < 40 && n < 500) begin tick; n++; end
    reset_n = 0;
    #1;
    chk("t5_rst_valid_x", sif.m_valid_x, 0); chk("t5_rst_valid_f", sif.m_valid_f, 0);
    chk("t5_rst_ready_y", sif.s_ready_y, 0); chk("t5_rst_busy", busy, 0);
    y_en = 0;
    tick; tick;
    reset_n = 1;
    tick;
    start_job(0);
    wait_done("t5", 2000);
    job_checks("t5");

    // 6: final x beat and final y beat on the same edge
    load(1);
    x_mode = 2; f_mode = 0; y_mode = 0; x_hold = 1; y_hold = 1;
    start_job(0);
    n = 0;
    while (!(x_beats == DATA_N-1 && y_beats == CONV_N-1) && n < 1000) begin tick; n++; end
    x_hold = 0; y_hold = 0;
    wait_done("t6", 100);
    chk("t6_same_cycle", last_x_cyc, last_y_cyc);
    chk("t6_done_next_cycle", done_cyc - last_y_cyc, 1);
    job_checks("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
